// File: rtl/par_rresp_arbiter_pkg.sv
// ============================================================================
// Module   : par_rresp_arbiter_pkg
// Purpose  : Shared AXI R-channel types and constants for the interconnect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package par_rresp_arbiter_pkg;

  localparam int AXI_IDW = 8;
  localparam int AXI_DW  = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Default-width R payload; blocks with other widths declare the same layout locally.
  typedef struct packed {
    logic [AXI_IDW-1:0] id;
    logic [AXI_DW-1:0]  data;
    logic [1:0]         resp;
    logic               last;
  } r_payload_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } r_state_e;

endpackage

`default_nettype wire

// File: rtl/par_rresp_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin search: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N    = 6,
  parameter int SELW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] idx_o,
  output logic            found_o
);

  always_comb begin
    int  cand;
    logic hit;
    idx_o = '0;
    hit   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!hit && cand < N && req_i[cand]) begin
        hit   = 1'b1;
        idx_o = SELW'(cand);
      end
    end
    found_o = hit;
  end

endmodule

`default_nettype wire

// File: rtl/par_rresp_arbiter.sv
// ============================================================================
// Module   : par_rresp_arbiter
// Purpose  : Merges InCount slave R channels onto one master R channel with
//            burst-locked round-robin grant and a registered output slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module par_rresp_arbiter
  import par_rresp_arbiter_pkg::*;
#(
  parameter int InCount = 6,
  parameter int selNum  = 3,
  parameter int IDW     = 8,
  parameter int DW      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InCount-1:0]     VALID_in,
  input  logic [InCount*IDW-1:0] RID_in,
  input  logic [InCount*DW-1:0]  RDATA_in,
  input  logic [InCount*2-1:0]   RRESP_in,
  input  logic [InCount-1:0]     RLAST_in,
  output logic [InCount-1:0]     READY_out,
  output logic                   RVALID_M,
  output logic [IDW-1:0]         RID_M,
  output logic [DW-1:0]          RDATA_M,
  output logic [1:0]             RRESP_M,
  output logic                   RLAST_M,
  input  logic                   RREADY_M,
  output logic [selNum-1:0]      grant_sel
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  r_state_e          state_q, state_d;
  logic [selNum-1:0] rr_ptr_q, rr_ptr_d;
  logic [selNum-1:0] grant_q, grant_d;
  logic              rvalid_q, rvalid_d;
  beat_t             beat_q, beat_d;

  logic [selNum-1:0] arb_idx;
  logic              arb_found;
  logic [selNum-1:0] gnt;
  logic              has_grant;
  logic              in_burst;
  logic              slot_free;
  logic              acc;
  beat_t             beat_in;

  rr_arbiter #(
    .N    (InCount),
    .SELW (selNum)
  ) u_rr_arbiter (
    .req_i   (VALID_in),
    .ptr_i   (rr_ptr_q),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rvalid_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      rvalid_q <= rvalid_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    rvalid_d  = rvalid_q;
    beat_d    = beat_q;
    READY_out = '0;

    // While a burst is open the grant is frozen; otherwise the arbiter decides.
    in_burst  = (state_q == BURST);
    gnt       = in_burst ? grant_q : arb_idx;
    has_grant = in_burst | arb_found;
    slot_free = !rvalid_q | RREADY_M;

    beat_in.id   = RID_in[gnt*IDW +: IDW];
    beat_in.data = RDATA_in[gnt*DW +: DW];
    beat_in.resp = RRESP_in[gnt*2 +: 2];
    beat_in.last = RLAST_in[gnt];

    acc       = has_grant & VALID_in[gnt] & slot_free;
    grant_sel = has_grant ? gnt : '0;
    if (has_grant) READY_out[gnt] = slot_free;

    if (acc) begin
      rvalid_d = 1'b1;
      beat_d   = beat_in;
      if (beat_in.last) begin
        state_d  = IDLE;
        rr_ptr_d = (int'(gnt) == InCount - 1) ? '0 : gnt + selNum'(1);
      end else if (!in_burst) begin
        state_d = BURST;
        grant_d = gnt;
      end
    end else if (rvalid_q & RREADY_M) begin
      rvalid_d = 1'b0;
    end
  end

  assign RVALID_M = rvalid_q;
  assign RID_M    = beat_q.id;
  assign RDATA_M  = beat_q.data;
  assign RRESP_M  = beat_q.resp;
  assign RLAST_M  = beat_q.last;

endmodule

`default_nettype wire

// File: tb/tb_par_rresp_arbiter.sv
// ============================================================================
// Module   : tb_par_rresp_arbiter
// Purpose  : Self-checking bench: directed scenarios plus randomized bursts
//            compared against a transaction-level round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_par_rresp_arbiter;
  import par_rresp_arbiter_pkg::*;

  localparam int N   = 6;
  localparam int SW  = 3;
  localparam int IW  = 8;
  localparam int DWD = 32;

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [DWD-1:0] data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  logic            clk, rst;
  logic [N-1:0]    VALID_in, RLAST_in, READY_out;
  logic [N*IW-1:0] RID_in;
  logic [N*DWD-1:0] RDATA_in;
  logic [N*2-1:0]  RRESP_in;
  logic            RVALID_M, RLAST_M, RREADY_M;
  logic [IW-1:0]   RID_M;
  logic [DWD-1:0]  RDATA_M;
  logic [1:0]      RRESP_M;
  logic [SW-1:0]   grant_sel;

  par_rresp_arbiter #(.InCount(N), .selNum(SW), .IDW(IW), .DW(DWD)) dut (
    .clk(clk), .rst(rst), .VALID_in(VALID_in), .RID_in(RID_in), .RDATA_in(RDATA_in),
    .RRESP_in(RRESP_in), .RLAST_in(RLAST_in), .READY_out(READY_out), .RVALID_M(RVALID_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RREADY_M(RREADY_M), .grant_sel(grant_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t        sq[N][$];
  beat_t        obs_q[$];
  int           obs_cyc[$];
  int           acc_cyc[$];
  int           cyc;
  logic [N-1:0] en;
  logic         rready;
  int           n_checks;
  int           n_fail;

  function automatic beat_t mk(int s, logic [31:0] d, logic l);
    beat_t b;
    b.id   = IW'(s);
    b.data = d;
    case ($urandom_range(0, 2))
      0:       b.resp = RESP_OKAY;
      1:       b.resp = RESP_SLVERR;
      default: b.resp = RESP_DECERR;
    endcase
    b.last = l;
    return b;
  endfunction

  task automatic clear_obs();
    obs_q.delete(); obs_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      VALID_in[s] = en[s] && (sq[s].size() > 0);
      if (VALID_in[s]) begin
        RID_in[s*IW +: IW]    = sq[s][0].id;
        RDATA_in[s*DWD +: DWD] = sq[s][0].data;
        RRESP_in[s*2 +: 2]    = sq[s][0].resp;
        RLAST_in[s]           = sq[s][0].last;
      end else begin
        RID_in[s*IW +: IW]    = '0;
        RDATA_in[s*DWD +: DWD] = '0;
        RRESP_in[s*2 +: 2]    = '0;
        RLAST_in[s]           = 1'b0;
      end
    end
    RREADY_M = rready;
  endtask

  // One clock: drive at negedge, sample handshakes, commit them at posedge.
  task automatic step();
    logic [N-1:0] hs;
    logic         mhs;
    beat_t        mb;
    drive();
    #1;
    hs  = VALID_in & READY_out;
    mhs = RVALID_M & RREADY_M;
    mb  = {RID_M, RDATA_M, RRESP_M, RLAST_M};
    n_checks++;
    if ((READY_out & (READY_out - 1'b1)) != '0) begin
      n_fail++; $display("FAIL ready_onehot got=%b required=one-hot or zero", READY_out);
    end
    n_checks++;
    if (RVALID_M && !RREADY_M && READY_out != '0) begin
      n_fail++; $display("FAIL ready_backpressure got=%b required=0", READY_out);
    end
    @(posedge clk);
    for (int s = 0; s < N; s++) if (hs[s]) void'(sq[s].pop_front());
    if (hs != '0) acc_cyc.push_back(cyc);
    if (mhs) begin obs_q.push_back(mb); obs_cyc.push_back(cyc); end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int n, input int bound, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < bound) begin step(); k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; rready = 1'b1;
    for (int s = 0; s < N; s++) sq[s].delete();
    step(); step();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    do_reset();
    drive(); #1;
    n_checks++;
    if ({RVALID_M, RID_M, RDATA_M, RRESP_M, RLAST_M} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h required=0", {RVALID_M, RID_M, RDATA_M, RRESP_M, RLAST_M});
    end
    n_checks++;
    if (grant_sel !== '0 || dut.rr_ptr_q !== 3'd0) begin
      n_fail++; $display("FAIL reset_grant got=%0d/%0d required=0/0", grant_sel, dut.rr_ptr_q);
    end
    for (int k = 0; k < 3; k++) begin
      step(); drive(); #1;
      n_checks++;
      if (READY_out !== '0) begin n_fail++; $display("FAIL idle_ready got=%b required=0", READY_out); end
    end
  endtask

  task automatic test_single_burst();
    bit ok;
    clear_obs(); en = '1; rready = 1'b1;
    for (int i = 0; i < 4; i++) sq[2].push_back(mk(2, 32'hA0 + i, i == 3));
    run_until(4, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout got=%0d beats required=4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i].data !== 32'hA0 + i || obs_q[i].id !== 8'd2 || obs_q[i].last !== (i == 3)
            || obs_cyc[i] !== obs_cyc[0] + i) begin
          n_fail++; $display("FAIL single_beat%0d got=%h required=%h", i, obs_q[i].data, 32'hA0 + i);
        end
      end
      n_checks++;
      if (obs_cyc[0] !== acc_cyc[0] + 1) begin
        n_fail++; $display("FAIL single_latency got=%0d required=%0d", obs_cyc[0], acc_cyc[0] + 1);
      end
    end
    n_checks++;
    if (dut.rr_ptr_q !== 3'd3) begin n_fail++; $display("FAIL single_rrptr got=%0d required=3", dut.rr_ptr_q); end
  endtask

  task automatic test_burst_lock();
    bit ok;
    int guard;
    logic [31:0] expd[6];
    clear_obs(); en = '1; rready = 1'b1;
    for (int i = 0; i < 4; i++) sq[1].push_back(mk(1, 32'hB0 + i, i == 3));
    guard = 0;
    while (acc_cyc.size() < 1 && guard < 10) begin step(); guard++; end
    sq[0].push_back(mk(0, 32'hC0, 1'b1));
    sq[3].push_back(mk(3, 32'hD0, 1'b1));
    guard = 0;
    while (sq[1].size() > 0 && guard < 20) begin
      drive(); #1;
      n_checks++;
      if (READY_out[0] !== 1'b0 || READY_out[3] !== 1'b0) begin
        n_fail++; $display("FAIL lock_ready got=%b required=bits0,3 low", READY_out);
      end
      step(); guard++;
    end
    run_until(6, 30, ok);
    expd = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hD0, 32'hC0};
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lock_timeout got=%0d beats required=6", obs_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs_q[i].data !== expd[i]) begin
        n_fail++; $display("FAIL lock_order%0d got=%h required=%h", i, obs_q[i].data, expd[i]);
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset(); en = '1;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++) sq[s].push_back(mk(s, 32'h100 * k + s, 1'b1));
    run_until(12, 40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL fair_timeout got=%0d beats required=12", obs_q.size()); end
    else begin
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (obs_q[i].id !== IW'(i % N)) begin
          n_fail++; $display("FAIL fair_order%0d got=%0d required=%0d", i, obs_q[i].id, i % N);
        end
      end
      n_checks++;
      if (obs_cyc[11] - obs_cyc[0] !== 11) begin
        n_fail++; $display("FAIL fair_throughput got=%0d cycles required=11", obs_cyc[11] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int guard;
    beat_t held;
    clear_obs(); en = '1; rready = 1'b1;
    for (int i = 0; i < 4; i++) sq[4].push_back(mk(4, 32'hE0 + i, i == 3));
    guard = 0;
    while (obs_q.size() < 1 && guard < 20) begin step(); guard++; end
    rready = 1'b0;
    drive(); #1;
    held = {RID_M, RDATA_M, RRESP_M, RLAST_M};
    for (int k = 0; k < 3; k++) begin
      drive(); #1;
      n_checks++;
      if (RVALID_M !== 1'b1 || {RID_M, RDATA_M, RRESP_M, RLAST_M} !== held || READY_out !== '0) begin
        n_fail++; $display("FAIL bp_hold%0d got=%b/%h/%b required=1/%h/0", k, RVALID_M, RDATA_M, READY_out, held.data);
      end
      step();
    end
    rready = 1'b1;
    run_until(4, 20, ok);
    step(); step(); step();
    n_checks++;
    if (!ok || obs_q.size() != 4) begin
      n_fail++; $display("FAIL bp_count got=%0d required=4", obs_q.size());
    end else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_q[i].data !== 32'hE0 + i) begin
        n_fail++; $display("FAIL bp_beat%0d got=%h required=%h", i, obs_q[i].data, 32'hE0 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    clear_obs(); en = '1; rready = 1'b1;
    for (int i = 0; i < 4; i++) sq[5].push_back(mk(5, 32'hF0 + i, i == 3));
    guard = 0;
    while (acc_cyc.size() < 2 && guard < 20) begin step(); guard++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int s = 0; s < N; s++) sq[s].delete();
    drive(); #1;
    n_checks++;
    if (RVALID_M !== 1'b0 || dut.state_q !== IDLE || dut.rr_ptr_q !== 3'd0) begin
      n_fail++; $display("FAIL rstmid got=%b/%0d/%0d required=0/IDLE/0", RVALID_M, dut.state_q, dut.rr_ptr_q);
    end
  endtask

  // Model: every loaded slave stays valid, so bursts leave in pure round-robin order.
  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      beat_t exp_q[$];
      beat_t mq[N][$];
      int    ptr, total, guard;
      do_reset(); en = '1;
      for (int s = 0; s < N; s++) begin
        int nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          int len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++) sq[s].push_back(mk(s, $urandom, i == len - 1));
        end
        mq[s] = sq[s];
      end
      ptr = 0;
      forever begin
        int win = -1;
        for (int k = 0; k < N && win < 0; k++)
          if (mq[(ptr + k) % N].size() > 0) win = (ptr + k) % N;
        if (win < 0) break;
        forever begin
          beat_t b = mq[win].pop_front();
          exp_q.push_back(b);
          if (b.last) break;
        end
        ptr = (win + 1) % N;
      end
      total = exp_q.size();
      guard = 0;
      while (obs_q.size() < total && guard < 600) begin
        rready = ($urandom_range(0, 99) < 70);
        step(); guard++;
      end
      n_checks++;
      if (obs_q.size() != total) begin
        n_fail++; $display("FAIL rand%0d_count got=%0d required=%0d", t, obs_q.size(), total);
      end else for (int i = 0; i < total; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_beat%0d got=%h required=%h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; en = '0; rready = 1'b0;
    drive();
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_burst_lock();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
